// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display blocks.
// Segment order is {A,B,C,D,E,F,G}, active-low.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG_HEX_F = 7'b0111000;

  // Width able to hold 0..n-1, never below one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_hex_rom.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational, shared with single-digit decoders.
module seven_seg_hex_rom
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_hex)
      4'h0: o_seg = SEG_HEX_0;
      4'h1: o_seg = SEG_HEX_1;
      4'h2: o_seg = SEG_HEX_2;
      4'h3: o_seg = SEG_HEX_3;
      4'h4: o_seg = SEG_HEX_4;
      4'h5: o_seg = SEG_HEX_5;
      4'h6: o_seg = SEG_HEX_6;
      4'h7: o_seg = SEG_HEX_7;
      4'h8: o_seg = SEG_HEX_8;
      4'h9: o_seg = SEG_HEX_9;
      4'hA: o_seg = SEG_HEX_A;
      4'hB: o_seg = SEG_HEX_B;
      4'hC: o_seg = SEG_HEX_C;
      4'hD: o_seg = SEG_HEX_D;
      4'hE: o_seg = SEG_HEX_E;
      4'hF: o_seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode hex display driver with
// frame-synchronous value swap, blanking, LZ suppress, blink.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    i_clock,
  input  logic                    i_resetn,
  input  logic                    i_enable,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_lz_suppress,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_load_ack,
  output logic                    o_frame_tick
);

  localparam int RW = clog2(REFRESH_DIV);
  localparam int BW = clog2(BLINK_DIV);
  localparam int IW = clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [RW-1:0]         r_ref_cnt;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_blink_on;
  logic [IW-1:0]         r_idx;
  logic                  r_pend;
  logic [VW-1:0]         r_pending;
  logic [VW-1:0]         r_active;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;

  logic                  w_ref_tc;
  logic                  w_blink_tc;
  logic                  w_boundary;
  logic [3:0]            w_digit;
  logic [6:0]            w_seg_lit;
  logic [NUM_DIGITS-1:0] w_an_lit;
  logic [NUM_DIGITS-1:0] w_hi_zero;
  logic                  w_run_zero;
  logic                  w_lz_sel;
  logic                  w_blink_sel;
  logic                  w_blank;

  assign w_ref_tc   = (r_ref_cnt == REF_LAST);
  assign w_blink_tc = (r_blink_cnt == BLK_LAST);
  assign w_boundary = w_ref_tc & (r_idx == IDX_LAST);

  assign o_frame_tick = w_boundary;
  assign o_load_ack   = w_boundary & (i_load | r_pend);
  assign o_an         = r_an;
  assign o_seg        = r_seg;

  // w_hi_zero[i]: active digits i..top are all zero
  always_comb begin
    w_run_zero  = 1'b1;
    w_hi_zero   = '0;
    w_digit     = 4'h0;
    w_lz_sel    = 1'b0;
    w_blink_sel = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run_zero   = w_run_zero & (r_active[i*4 +: 4] == 4'h0);
      w_hi_zero[i] = w_run_zero;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_digit     = r_active[i*4 +: 4];
        w_lz_sel    = (i > 0) & w_hi_zero[i];
        w_blink_sel = i_blink_mask[i];
      end
    end
  end

  assign w_blank = ~i_enable
                 | (~r_blink_on & w_blink_sel)
                 | (i_lz_suppress & w_lz_sel);

  assign w_an_lit = ~(NUM_DIGITS'(1) << r_idx);

  seven_seg_hex_rom u_rom (
    .i_hex (w_digit),
    .o_seg (w_seg_lit)
  );

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_ref_cnt <= '0;
      r_idx     <= '0;
    end else if (w_ref_tc) begin
      r_ref_cnt <= '0;
      r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_blink_tc) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // A load on the boundary wins over anything still pending
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_pend    <= 1'b0;
      r_pending <= '0;
      r_active  <= '0;
    end else if (w_boundary) begin
      r_pend <= 1'b0;
      if (i_load) begin
        r_active <= i_value;
      end else if (r_pend) begin
        r_active <= r_pending;
      end
    end else if (i_load) begin
      r_pend    <= 1'b1;
      r_pending <= i_value;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else if (w_blank) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_an_lit;
      r_seg <= w_seg_lit;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver.
// 4 digits, 4-cycle slots, 32-cycle blink half-period.
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        ld;
  logic [15:0] val;
  logic        lz;
  logic [3:0]  bmask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        ack;
  logic        tick;

  int n_checks = 0;
  int n_err    = 0;
  int k;

  localparam logic [10:0] BLANK = {4'hF, 7'b1111111};

  seven_seg_scan_driver #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLINK_DIV   (32)
  ) dut (
    .i_clock       (clk),
    .i_resetn      (rst_n),
    .i_enable      (en),
    .i_load        (ld),
    .i_value       (val),
    .i_lz_suppress (lz),
    .i_blink_mask  (bmask),
    .o_an          (an),
    .o_seg         (seg),
    .o_load_ack    (ack),
    .o_frame_tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edges since reset release, mirrors the DUT's free-running counters
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] lit(input int d, input logic [6:0] s);
    logic [3:0] a;
    a = 4'b0001 << d;
    return {~a, s};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] v);
    val = v;
    ld  = 1'b1;
    @(negedge clk);
    ld  = 1'b0;
  endtask

  task automatic wait_tick();
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk);
      hit = tick;
    end
    if (!hit) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  // called on a tick negedge; checks the four slots of the next frame
  task automatic frame_check(input string tag, input logic [43:0] e);
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_d%0d", tag, d), 32'({an, seg}), 32'(e[d*11 +: 11]));
      if (d < 3) step(4);
    end
  endtask

  initial begin
    int kf;
    int k0;
    int s;
    int d;
    logic [10:0] e;
    rst_n = 1'b1;
    en    = 1'b0;
    ld    = 1'b0;
    val   = '0;
    lz    = 1'b0;
    bmask = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    #9;
    rst_n = 1'b1;
    en    = 1'b1;

    kf = -1;
    for (int n = 0; n < 20 && kf < 0; n++) begin
      @(negedge clk);
      if (tick) kf = k;
    end
    chk("first_tick_k", 32'(kf), 32'd15);
    chk("first_tick_ack", 32'(ack), 32'd0);

    step(1);
    pulse(16'h12AF);
    wait_tick();
    chk("ack_12af", 32'(ack), 32'd1);
    frame_check("f12af", {lit(3, 7'b1001111), lit(2, 7'b0010010),
                          lit(1, 7'b0001000), lit(0, 7'b0111000)});
    wait_tick();
    chk("ack_once", 32'(ack), 32'd0);

    step(1);
    pulse(16'h1111);
    pulse(16'h2222);
    wait_tick();
    chk("ack_2222", 32'(ack), 32'd1);
    frame_check("f2222", {lit(3, 7'b0010010), lit(2, 7'b0010010),
                          lit(1, 7'b0010010), lit(0, 7'b0010010)});
    wait_tick();
    chk("ack_2222_single", 32'(ack), 32'd0);

    step(1);
    pulse(16'h7777);
    wait_tick();
    val = 16'h3456;
    ld  = 1'b1;
    #1;
    chk("ack_on_boundary", 32'(ack), 32'd1);
    frame_check("f3456", {lit(3, 7'b0000110), lit(2, 7'b1001100),
                          lit(1, 7'b0100100), lit(0, 7'b0100000)});
    wait_tick();
    chk("stale_discarded", 32'(ack), 32'd0);

    lz = 1'b1;
    step(1);
    pulse(16'h0040);
    wait_tick();
    chk("ack_0040", 32'(ack), 32'd1);
    frame_check("flz40", {BLANK, BLANK,
                          lit(1, 7'b1001100), lit(0, 7'b0000001)});
    wait_tick();
    step(1);
    pulse(16'h0000);
    wait_tick();
    frame_check("flz00", {BLANK, BLANK, BLANK, lit(0, 7'b0000001)});

    lz = 1'b0;
    wait_tick();
    step(1);
    pulse(16'h0040);
    wait_tick();
    step(1);
    bmask = 4'b0001;
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      s = k - 1;
      d = (s >> 2) & 3;
      if (d == 0 && ((s >> 5) & 1) == 1) e = BLANK;
      else e = lit(d, (d == 1) ? 7'b1001100 : 7'b0000001);
      chk($sformatf("blink_k%0d", k), 32'({an, seg}), 32'(e));
    end
    bmask = 4'b0000;

    wait_tick();
    k0 = k;
    step(3);
    en = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (n == 2) begin
        val = 16'h0BCD;
        ld  = 1'b1;
      end
      if (n == 3) ld = 1'b0;
      chk($sformatf("dis_%0d", n), 32'({an, seg}), 32'(BLANK));
    end
    en = 1'b1;
    wait_tick();
    chk("dis_period", 32'(k - k0), 32'd16);
    chk("dis_ack", 32'(ack), 32'd1);
    frame_check("f0bcd", {lit(3, 7'b0000001), lit(2, 7'b1100000),
                          lit(1, 7'b0110001), lit(0, 7'b1000010)});

    step(3);
    pulse(16'h9999);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    #6 rst_n = 1'b1;
    kf = -1;
    for (int n = 0; n < 20 && kf < 0; n++) begin
      @(negedge clk);
      if (tick) kf = k;
    end
    chk("rst2_tick_k", 32'(kf), 32'd15);
    chk("rst2_pend_lost", 32'(ack), 32'd0);
    frame_check("fzero", {lit(3, 7'b0000001), lit(2, 7'b0000001),
                          lit(1, 7'b0000001), lit(0, 7'b0000001)});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
